// File: rtl/relu_pool_stream_if.sv
// Valid/ready stream bundle; the producer side uses master, the consumer side uses slave.
interface relu_pool_stream_if #(
    parameter int unsigned W = 64
) ();
    logic         vld;
    logic         rdy;
    logic [W-1:0] data;

    modport master (output vld, output data, input rdy);
    modport slave  (input vld, input data, output rdy);
endinterface

// File: rtl/relu_pool_stream.sv
// Streaming requantize (round-half-up shift, saturate, optional ReLU) followed by
// a per-lane max-pool over WIN accepted beats, with valid/ready on both sides.
module relu_pool_stream #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 8,
    parameter int unsigned SHIFT = 7,
    parameter int unsigned LANES = 4,
    parameter int unsigned WIN   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sync_clr,
    input  logic                relu_en,
    relu_pool_stream_if.slave   in_s,
    relu_pool_stream_if.master  out_m,
    output logic [7:0]          win_cnt
);

    localparam int unsigned EXT_W  = IN_W + 1;
    localparam int unsigned RND_SH = (SHIFT == 0) ? 0 : SHIFT - 1;
    localparam logic signed [EXT_W-1:0] RND    = EXT_W'((SHIFT == 0) ? 0 : (1 << RND_SH));
    localparam logic signed [EXT_W-1:0] SAT_HI = EXT_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [EXT_W-1:0] SAT_LO = EXT_W'(-(1 << (OUT_W - 1)));
    localparam logic [7:0]              LAST   = 8'(WIN - 1);

    // Reject parameter sets the datapath cannot represent.
    if (OUT_W > IN_W || SHIFT >= IN_W || WIN < 1 || WIN > 256 || LANES < 1) begin : g_param_check
        $error("relu_pool_stream: illegal parameter combination");
    end

    logic                     en;
    logic                     accept;
    logic                     last_beat;
    logic                     s1_vld;
    logic                     out_vld_q;
    logic [LANES*OUT_W-1:0]   out_data_q;
    logic [LANES*OUT_W-1:0]   pool_flat_c;

    logic signed [EXT_W-1:0]  ext_c  [LANES];
    logic signed [EXT_W-1:0]  rnd_c  [LANES];
    logic signed [OUT_W-1:0]  q_c    [LANES];
    logic signed [OUT_W-1:0]  pool_c [LANES];
    logic signed [OUT_W-1:0]  s1_q   [LANES];
    logic signed [OUT_W-1:0]  acc    [LANES];

    // Everything advances together unless a result is waiting on downstream.
    assign en        = !out_vld_q || out_m.rdy;
    assign in_s.rdy  = en && !sync_clr;
    assign accept    = in_s.vld && in_s.rdy;
    assign last_beat = (win_cnt == LAST);

    assign out_m.vld  = out_vld_q;
    assign out_m.data = out_data_q;

    // Stage-1 arithmetic: one extra bit of headroom so the rounding add cannot wrap.
    always_comb begin
        ext_c = '{default: '0};
        rnd_c = '{default: '0};
        q_c   = '{default: '0};
        for (int i = 0; i < LANES; i++) begin
            ext_c[i] = EXT_W'($signed(in_s.data[i*IN_W +: IN_W]));
            rnd_c[i] = (ext_c[i] + RND) >>> SHIFT;
            if (rnd_c[i] > SAT_HI) begin
                q_c[i] = SAT_HI[OUT_W-1:0];
            end else if (rnd_c[i] < SAT_LO) begin
                q_c[i] = SAT_LO[OUT_W-1:0];
            end else begin
                q_c[i] = rnd_c[i][OUT_W-1:0];
            end
            if (relu_en && q_c[i][OUT_W-1]) begin
                q_c[i] = '0;
            end
        end
    end

    // Running signed max; the first beat of a window replaces the accumulator.
    always_comb begin
        pool_c      = '{default: '0};
        pool_flat_c = '0;
        for (int i = 0; i < LANES; i++) begin
            if (win_cnt == 8'd0 || s1_q[i] > acc[i]) begin
                pool_c[i] = s1_q[i];
            end else begin
                pool_c[i] = acc[i];
            end
            pool_flat_c[i*OUT_W +: OUT_W] = pool_c[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld     <= 1'b0;
            s1_q       <= '{default: '0};
            acc        <= '{default: '0};
            win_cnt    <= 8'd0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
        end else if (sync_clr) begin
            s1_vld     <= 1'b0;
            acc        <= '{default: '0};
            win_cnt    <= 8'd0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
        end else if (en) begin
            s1_vld <= accept;
            if (accept) begin
                s1_q <= q_c;
            end
            if (s1_vld) begin
                acc <= pool_c;
                if (last_beat) begin
                    out_data_q <= pool_flat_c;
                    out_vld_q  <= 1'b1;
                    win_cnt    <= 8'd0;
                end else begin
                    out_vld_q  <= 1'b0;
                    win_cnt    <= win_cnt + 8'd1;
                end
            end else begin
                out_vld_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_relu_pool_stream.sv
// Directed bench for relu_pool_stream: one instance with WIN=1 and one with WIN=4.
module tb_relu_pool_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sync_clr;
    logic       relu_en;
    logic [7:0] win_cnt1;
    logic [7:0] win_cnt4;

    int n_vec  = 0;
    int n_miss = 0;

    relu_pool_stream_if #(.W(64)) in1  ();
    relu_pool_stream_if #(.W(32)) out1 ();
    relu_pool_stream_if #(.W(64)) in4  ();
    relu_pool_stream_if #(.W(32)) out4 ();

    relu_pool_stream #(.WIN(1)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .sync_clr (sync_clr),
        .relu_en  (relu_en),
        .in_s     (in1),
        .out_m    (out1),
        .win_cnt  (win_cnt1)
    );

    relu_pool_stream #(.WIN(4)) dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .sync_clr (sync_clr),
        .relu_en  (relu_en),
        .in_s     (in4),
        .out_m    (out4),
        .win_cnt  (win_cnt4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference requantizer for the default IN_W=16, OUT_W=8, SHIFT=7.
    function automatic logic [7:0] quant(input logic [15:0] x, input logic relu);
        int v;
        v = int'($signed(x));
        v = (v + 64) >>> 7;
        if (v > 127)  v = 127;
        if (v < -128) v = -128;
        if (relu && v < 0) v = 0;
        return 8'(v);
    endfunction

    function automatic logic [31:0] q4(input logic [63:0] b, input logic relu);
        logic [31:0] r;
        r = '0;
        for (int l = 0; l < 4; l++) r[l*8 +: 8] = quant(b[l*16 +: 16], relu);
        return r;
    endfunction

    function automatic logic [31:0] pool4(input logic [63:0] b [4], input logic relu);
        logic [31:0] r;
        logic [31:0] q;
        r = q4(b[0], relu);
        for (int k = 1; k < 4; k++) begin
            q = q4(b[k], relu);
            for (int l = 0; l < 4; l++) begin
                if ($signed(q[l*8 +: 8]) > $signed(r[l*8 +: 8])) r[l*8 +: 8] = q[l*8 +: 8];
            end
        end
        return r;
    endfunction

    logic [63:0] t3b  [4];
    logic [63:0] t4b  [12];
    logic [63:0] w4   [4];
    logic [31:0] t4e  [3];
    logic [63:0] t5c  [4];
    logic [63:0] t6b  [4];
    logic [63:0] strm [8];
    logic [31:0] hold;
    logic        have_hold;
    int          sent, got, cyc, n_stall;

    initial begin
        rst_n    = 1'b0;
        sync_clr = 1'b0;
        relu_en  = 1'b0;
        in1.vld  = 1'b0;
        in1.data = '0;
        in4.vld  = 1'b0;
        in4.data = '0;
        out1.rdy = 1'b1;
        out4.rdy = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_vld1",  64'(out1.vld),  64'd0);
        check("rst_vld4",  64'(out4.vld),  64'd0);
        check("rst_data4", 64'(out4.data), 64'd0);
        check("rst_cnt4",  64'(win_cnt4),  64'd0);
        rst_n = 1'b1;

        // Rounding and ReLU, WIN=1
        relu_en  = 1'b1;
        in1.vld  = 1'b1;
        in1.data = 64'hFF38_003F_0040_00C0;
        tick();
        check("t1_s1_only", 64'(out1.vld), 64'd0);
        in1.vld = 1'b0;
        tick();
        check("t1_vld",  64'(out1.vld),  64'd1);
        check("t1_data", 64'(out1.data), 64'h0000_0102);

        // Saturation without ReLU
        relu_en  = 1'b0;
        in1.vld  = 1'b1;
        in1.data = 64'h3F80_FF38_8000_7FFF;
        tick();
        in1.vld = 1'b0;
        tick();
        check("t2_data", 64'(out1.data), 64'h7FFE_807F);
        tick();
        check("t2_drop", 64'(out1.vld), 64'd0);

        // Pooling over 4 beats, lane 0 only
        relu_en = 1'b1;
        t3b = '{64'h0100, 64'h0400, 64'h0180, 64'h0080};
        for (int i = 0; i < 4; i++) begin
            in4.vld  = 1'b1;
            in4.data = t3b[i];
            tick();
            check("t3_cnt", 64'(win_cnt4), 64'(i));
            check("t3_novld", 64'(out4.vld), 64'd0);
        end
        in4.vld = 1'b0;
        tick();
        check("t3_cnt_wrap", 64'(win_cnt4),  64'd0);
        check("t3_vld",      64'(out4.vld),  64'd1);
        check("t3_data",     64'(out4.data), 64'h0000_0008);
        tick();
        check("t3_pulse", 64'(out4.vld), 64'd0);

        // Backpressure across three random windows
        relu_en = 1'b0;
        for (int i = 0; i < 12; i++) t4b[i] = {$urandom, $urandom};
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < 4; k++) w4[k] = t4b[w*4 + k];
            t4e[w] = pool4(w4, 1'b0);
        end
        sent = 0; got = 0; cyc = 0; n_stall = 0; have_hold = 1'b0; hold = '0;
        while (got < 3 && cyc < 60) begin
            out4.rdy = !(cyc >= 9 && cyc <= 13);
            in4.vld  = (sent < 12);
            in4.data = (sent < 12) ? t4b[sent] : 64'd0;
            #1;
            if (out4.vld && !out4.rdy) begin
                if (!have_hold) begin
                    hold      = out4.data;
                    have_hold = 1'b1;
                end
                n_stall++;
                check("t4_stall_rdy",  64'(in4.rdy),   64'd0);
                check("t4_stall_data", 64'(out4.data), 64'(hold));
            end
            if (out4.vld && out4.rdy) begin
                check("t4_result", 64'(out4.data), 64'(t4e[got]));
                got++;
            end
            if (in4.vld && in4.rdy) sent++;
            @(posedge clk);
            #1;
            cyc++;
        end
        in4.vld  = 1'b0;
        out4.rdy = 1'b1;
        check("t4_results",     64'(got),     64'd3);
        check("t4_stall_count", 64'(n_stall), 64'd5);
        tick();

        // sync_clr aborts a partial window
        relu_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in4.vld  = 1'b1;
            in4.data = 64'h0000_0000_3F80_3F80;
            tick();
        end
        sync_clr = 1'b1;
        #1;
        check("t5_rdy_clr", 64'(in4.rdy), 64'd0);
        tick();
        sync_clr = 1'b0;
        check("t5_cnt_clr", 64'(win_cnt4), 64'd0);
        t5c = '{64'h0000_0000_FF38_0080, 64'h0000_0000_FF38_0100,
                64'h0000_0000_FF38_0180, 64'h0000_0000_FF38_0000};
        for (int i = 0; i < 4; i++) begin
            in4.vld  = 1'b1;
            in4.data = t5c[i];
            tick();
        end
        in4.vld = 1'b0;
        tick();
        check("t5_vld",  64'(out4.vld),  64'd1);
        check("t5_data", 64'(out4.data), 64'h0000_FE03);
        tick();

        // sync_clr while a result is pending
        out4.rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in4.vld  = 1'b1;
            in4.data = t5c[i];
            tick();
        end
        in4.vld = 1'b0;
        tick();
        tick();
        check("t5_pending", 64'(out4.vld), 64'd1);
        sync_clr = 1'b1;
        tick();
        sync_clr = 1'b0;
        check("t5_clr_vld",  64'(out4.vld),  64'd0);
        check("t5_clr_data", 64'(out4.data), 64'd0);
        out4.rdy = 1'b1;
        tick();

        // Async reset mid-window with a result pending and a beat in stage 1
        relu_en  = 1'b1;
        out4.rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in4.vld  = 1'b1;
            in4.data = (i < 4) ? t5c[i] : 64'h0000_3F80_0000_0000;
            tick();
        end
        in4.vld = 1'b0;
        check("t6_pending", 64'(out4.vld), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_vld",  64'(out4.vld),  64'd0);
        check("t6_rst_data", 64'(out4.data), 64'd0);
        check("t6_rst_cnt",  64'(win_cnt4),  64'd0);
        rst_n    = 1'b1;
        out4.rdy = 1'b1;
        t6b = '{64'h0000_8000_0000_0000, 64'h0000_0280_0000_0000,
                64'h0000_00C8_0000_0000, 64'h0000_0180_0000_0000};
        for (int i = 0; i < 4; i++) begin
            in4.vld  = 1'b1;
            in4.data = t6b[i];
            tick();
        end
        in4.vld = 1'b0;
        tick();
        check("t6_vld",  64'(out4.vld),  64'd1);
        check("t6_data", 64'(out4.data), 64'h0005_0000);

        // Full-throughput stream at WIN=1
        relu_en = 1'b0;
        for (int i = 0; i < 8; i++) strm[i] = {$urandom, $urandom};
        for (int c = 0; c <= 8; c++) begin
            in1.vld  = (c < 8);
            in1.data = (c < 8) ? strm[c] : 64'd0;
            tick();
            if (c >= 1) begin
                check("t6_strm_vld",  64'(out1.vld),  64'd1);
                check("t6_strm_data", 64'(out1.data), 64'(q4(strm[c-1], 1'b0)));
            end
        end
        in1.vld = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
